// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states,
// the NOP used as the idle instruction, and PC stepping constants.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Word-align an address by clearing the two byte-offset bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_pc_gen.sv
// Program counter for the fetch stage: holds the PC, steps it by one
// instruction, and takes redirects with the target forced word-aligned.
module pc_gen
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic [31:0] pc
);

    logic [31:0] pc_next;

    // Redirect wins over the sequential step; +4 wraps naturally at 2^32.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = align_word(redirect_addr);
        end else if (advance) begin
            pc_next = pc + INSTR_BYTES;
        end
    end

    // PC register, restarting at the reset vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= align_word(RESET_PC);
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding request to instruction memory,
// registered presentation of each returned word, stall buffering and
// redirect handling that discards responses to abandoned requests.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pause,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        pc_from_rom_ready
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic        advance;
    logic        present;
    logic [31:0] present_pc;
    logic [31:0] present_instr;
    logic        capture;
    logic        release_hold;

    logic        hold_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .advance       (advance),
        .redirect      (jump_en),
        .redirect_addr (jump_addr),
        .pc            (pc)
    );

    // Request side comes only from registers so memory never sees a
    // combinational path from our inputs.
    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;

    // Next-state and per-cycle actions; a redirect pre-empts everything and
    // lands in DROP only when a request is still in flight afterwards.
    always_comb begin
        state_next    = state;
        advance       = 1'b0;
        present       = 1'b0;
        present_pc    = pc;
        present_instr = imem_resp_data;
        capture       = 1'b0;
        release_hold  = 1'b0;
        case (state)
            REQ: begin
                if (jump_en) begin
                    state_next = imem_req_ready ? DROP : REQ;
                end else if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (jump_en) begin
                    state_next = imem_resp_valid ? REQ : DROP;
                end else if (imem_resp_valid) begin
                    if (pause) begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end else begin
                        present    = 1'b1;
                        advance    = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            HOLD: begin
                if (jump_en) begin
                    state_next = REQ;
                end else if (!pause) begin
                    present       = hold_valid;
                    present_pc    = hold_pc;
                    present_instr = hold_instr;
                    release_hold  = 1'b1;
                    advance       = 1'b1;
                    state_next    = REQ;
                end
            end
            DROP: begin
                if (jump_en) begin
                    state_next = imem_resp_valid ? REQ : DROP;
                end else if (imem_resp_valid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // Hold buffer keeps a word that arrived while the pipeline was stalled;
    // a redirect throws it away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_pc    <= 32'h0;
            hold_instr <= NOP_INSTR;
        end else if (jump_en) begin
            hold_valid <= 1'b0;
        end else if (capture) begin
            hold_valid <= 1'b1;
            hold_pc    <= pc;
            hold_instr <= imem_resp_data;
        end else if (release_hold) begin
            hold_valid <= 1'b0;
        end
    end

    // Registered presentation to IF/ID; pc/instr hold between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pc             <= 32'h0;
            if_instr          <= NOP_INSTR;
            pc_from_rom_ready <= 1'b0;
        end else begin
            pc_from_rom_ready <= present;
            if (present) begin
                if_pc    <= present_pc;
                if_instr <= present_instr;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: a per-cycle vector table for the basic stream,
// then a memory model with a strobe scoreboard for redirect, stall, wrap
// and reset corner cases plus a randomized mix.
module tb_if_fetch;

    localparam logic [31:0] TB_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pause;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        pc_from_rom_ready;

    if_fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pause             (pause),
        .jump_en           (jump_en),
        .jump_addr         (jump_addr),
        .imem_req_valid    (imem_req_valid),
        .imem_req_addr     (imem_req_addr),
        .imem_req_ready    (imem_req_ready),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .if_pc             (if_pc),
        .if_instr          (if_instr),
        .pc_from_rom_ready (pc_from_rom_ready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobes_seen = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } strobe_t;

    strobe_t sb_q[$];

    logic        pending;
    logic        pend_stale;
    int          pend_count;
    logic [31:0] pend_addr;
    logic        held;
    strobe_t     held_entry;
    logic        exp_strobe;
    logic [31:0] exp_pc;
    int          latency;
    logic        rand_ready;

    typedef struct {
        logic        ready;
        logic        resp;
        logic        pse;
        logic        jmp;
        logic [31:0] jaddr;
        logic [31:0] rdata;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic        exp_strobe;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t tbl[15];

    // Instruction memory contents: any address-dependent pattern distinct from NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_1013;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rsp, input logic p, input logic j,
                                input logic [31:0] ja, input logic [31:0] rd,
                                input logic ev, input logic [31:0] ea, input logic es,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.ready = rdy; v.resp = rsp; v.pse = p; v.jmp = j; v.jaddr = ja; v.rdata = rd;
        v.exp_valid = ev; v.exp_addr = ea; v.exp_strobe = es; v.exp_pc = ep; v.exp_instr = ei;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Compare this cycle's presentation against the scoreboard.
    task automatic checkOutput();
        strobe_t e;
        check1("strobe", pc_from_rom_ready, exp_strobe);
        if (pc_from_rom_ready) strobes_seen++;
        if (exp_strobe) begin
            if (sb_q.size() == 0) begin
                check1("scoreboard_nonempty", 1'b0, 1'b1);
            end else begin
                e = sb_q.pop_front();
                check32("if_pc", if_pc, e.pc);
                check32("if_instr", if_instr, e.instr);
            end
        end
    endtask

    // One cycle at a negedge: check outputs, run the memory model, predict
    // what the next edge should present, and drive the inputs.
    task automatic applyStimulus(input logic p, input logic j, input logic [31:0] ja);
        logic        resp;
        logic        resp_stale;
        logic [31:0] resp_addr;
        logic        rdy;
        logic        exp_next;
        strobe_t     e;
        checkOutput();
        if (imem_req_valid) check32("req_addr", imem_req_addr, exp_pc);
        resp = 1'b0;
        resp_stale = 1'b0;
        resp_addr = 32'h0;
        if (pending) begin
            if (pend_count == 0) begin
                resp = 1'b1;
                resp_stale = pend_stale;
                resp_addr = pend_addr;
                pending = 1'b0;
            end else begin
                pend_count--;
            end
        end
        rdy = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        exp_next = 1'b0;
        if (j) begin
            held = 1'b0;
        end else if (held && !p) begin
            sb_q.push_back(held_entry);
            exp_next = 1'b1;
            held = 1'b0;
            exp_pc = exp_pc + 32'd4;
        end else if (resp && !resp_stale) begin
            e.pc = resp_addr;
            e.instr = mem_word(resp_addr);
            if (p) begin
                held = 1'b1;
                held_entry = e;
            end else begin
                sb_q.push_back(e);
                exp_next = 1'b1;
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (rdy && imem_req_valid) begin
            pending = 1'b1;
            pend_addr = exp_pc;
            pend_count = latency - 1;
            pend_stale = j;
        end else if (j && pending) begin
            pend_stale = 1'b1;
        end
        if (j) exp_pc = ja & 32'hFFFF_FFFC;
        pause = p;
        jump_en = j;
        jump_addr = ja;
        imem_req_ready = rdy;
        imem_resp_valid = resp;
        imem_resp_data = resp ? mem_word(resp_addr) : 32'hDEAD_BEEF;
        exp_strobe = exp_next;
    endtask

    // Assert reset now, clear the model, release on a negedge.
    task automatic doReset();
        rst_n = 1'b0;
        pause = 1'b0;
        jump_en = 1'b0;
        jump_addr = 32'h0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        pending = 1'b0;
        pend_stale = 1'b0;
        pend_count = 0;
        pend_addr = 32'h0;
        held = 1'b0;
        exp_strobe = 1'b0;
        exp_pc = 32'h0;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic expectNextReq(input string name, input logic [31:0] a);
        logic hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk);
            if (imem_req_valid) begin
                check32(name, imem_req_addr, a);
                hit = 1'b1;
            end
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        if (!hit) check1({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic expectNextStrobe(input string name, input logic [31:0] a);
        logic hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk);
            if (pc_from_rom_ready) begin
                check32(name, if_pc, a);
                hit = 1'b1;
            end
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        if (!hit) check1({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic found;
        latency = 1;
        rand_ready = 1'b0;

        tbl[0]  = mk(1, 0, 0, 0, 32'h0,   32'h0,              1, 32'h0,   0, 32'h0,   TB_NOP);
        tbl[1]  = mk(1, 1, 0, 0, 32'h0,   mem_word(32'h0),    0, 32'h0,   0, 32'h0,   TB_NOP);
        tbl[2]  = mk(1, 0, 0, 0, 32'h0,   32'h0,              1, 32'h4,   1, 32'h0,   mem_word(32'h0));
        tbl[3]  = mk(1, 1, 0, 0, 32'h0,   mem_word(32'h4),    0, 32'h4,   0, 32'h0,   mem_word(32'h0));
        tbl[4]  = mk(1, 0, 0, 0, 32'h0,   32'h0,              1, 32'h8,   1, 32'h4,   mem_word(32'h4));
        tbl[5]  = mk(1, 1, 1, 0, 32'h0,   mem_word(32'h8),    0, 32'h8,   0, 32'h4,   mem_word(32'h4));
        tbl[6]  = mk(1, 0, 1, 0, 32'h0,   32'h0,              0, 32'h8,   0, 32'h4,   mem_word(32'h4));
        tbl[7]  = mk(1, 0, 1, 0, 32'h0,   32'h0,              0, 32'h8,   0, 32'h4,   mem_word(32'h4));
        tbl[8]  = mk(1, 0, 0, 0, 32'h0,   32'h0,              0, 32'h8,   0, 32'h4,   mem_word(32'h4));
        tbl[9]  = mk(1, 0, 0, 0, 32'h0,   32'h0,              1, 32'hC,   1, 32'h8,   mem_word(32'h8));
        tbl[10] = mk(1, 1, 0, 0, 32'h0,   mem_word(32'hC),    0, 32'hC,   0, 32'h8,   mem_word(32'h8));
        tbl[11] = mk(0, 0, 0, 1, 32'h103, 32'h0,              1, 32'h10,  1, 32'hC,   mem_word(32'hC));
        tbl[12] = mk(1, 0, 0, 0, 32'h0,   32'h0,              1, 32'h100, 0, 32'hC,   mem_word(32'hC));
        tbl[13] = mk(1, 1, 0, 0, 32'h0,   mem_word(32'h100),  0, 32'h100, 0, 32'hC,   mem_word(32'hC));
        tbl[14] = mk(1, 0, 0, 0, 32'h0,   32'h0,              1, 32'h104, 1, 32'h100, mem_word(32'h100));

        // Reset values while reset is held.
        rst_n = 1'b0;
        pause = 1'b0;
        jump_en = 1'b0;
        jump_addr = 32'h0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        #12;
        check32("reset_if_pc", if_pc, 32'h0);
        check32("reset_if_instr", if_instr, TB_NOP);
        check1("reset_strobe", pc_from_rom_ready, 1'b0);

        $display("[TB] vector table: stream, pause, redirect in REQ");
        doReset();
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            check1($sformatf("v%0d_req_valid", i), imem_req_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) check32($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
            check1($sformatf("v%0d_strobe", i), pc_from_rom_ready, tbl[i].exp_strobe);
            check32($sformatf("v%0d_if_pc", i), if_pc, tbl[i].exp_pc);
            check32($sformatf("v%0d_if_instr", i), if_instr, tbl[i].exp_instr);
            imem_req_ready = tbl[i].ready;
            imem_resp_valid = tbl[i].resp;
            imem_resp_data = tbl[i].rdata;
            pause = tbl[i].pse;
            jump_en = tbl[i].jmp;
            jump_addr = tbl[i].jaddr;
        end

        $display("[TB] redirect while waiting without response");
        doReset();
        latency = 3;
        applyStimulus(1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (!imem_req_valid && pending && pend_count != 0 && !pend_stale) begin
                applyStimulus(1'b0, 1'b1, 32'h0000_0103);
                found = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0);
            end
        end
        check1("wait_jump_reached", found, 1'b1);
        expectNextReq("wait_jump_req", 32'h100);
        expectNextStrobe("wait_jump_strobe", 32'h100);

        $display("[TB] redirect coinciding with response");
        doReset();
        latency = 1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (!imem_req_valid && pending && pend_count == 0) begin
                applyStimulus(1'b0, 1'b1, 32'h0000_0200);
                found = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0);
            end
        end
        check1("resp_jump_reached", found, 1'b1);
        @(negedge clk);
        check1("resp_jump_req_valid", imem_req_valid, 1'b1);
        check32("resp_jump_req_addr", imem_req_addr, 32'h200);
        applyStimulus(1'b0, 1'b0, 32'h0);
        expectNextStrobe("resp_jump_strobe", 32'h200);

        $display("[TB] redirect while holding a stalled word");
        doReset();
        latency = 1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (!imem_req_valid && pending && pend_count == 0) begin
                applyStimulus(1'b1, 1'b0, 32'h0);
                found = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0);
            end
        end
        check1("hold_jump_reached", found, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h0000_0300);
        @(negedge clk);
        check1("hold_jump_req_valid", imem_req_valid, 1'b1);
        check32("hold_jump_req_addr", imem_req_addr, 32'h300);
        applyStimulus(1'b0, 1'b0, 32'h0);
        expectNextStrobe("hold_jump_strobe", 32'h300);

        $display("[TB] PC wrap at top of address space");
        doReset();
        latency = 1;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        expectNextStrobe("wrap_strobe_top", 32'hFFFF_FFFC);
        check1("wrap_req_valid", imem_req_valid, 1'b1);
        check32("wrap_req_addr", imem_req_addr, 32'h0);
        expectNextStrobe("wrap_strobe_zero", 32'h0);

        $display("[TB] randomized stalls, backpressure and redirects");
        doReset();
        latency = 2;
        rand_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                          {20'h0, 12'($urandom_range(0, 4095))});
        end
        idle(12);
        rand_ready = 1'b0;

        $display("[TB] reset asserted mid-wait");
        doReset();
        latency = 4;
        strobes_seen = 0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (strobes_seen >= 1 && !imem_req_valid && pending && pend_count >= 1) begin
                found = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0);
            end
        end
        check1("reset_wait_reached", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check32("midreset_if_pc", if_pc, 32'h0);
        check32("midreset_if_instr", if_instr, TB_NOP);
        check1("midreset_strobe", pc_from_rom_ready, 1'b0);
        doReset();
        check1("restart_req_valid", imem_req_valid, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        expectNextStrobe("restart_strobe", 32'h0);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage pipeline, directly upstream of the IF/ID register. Owns the program counter, issues one-at-a-time fetch requests to the instruction cache/ROM over a valid/ready request and valid response interface, and presents each returned instruction with its PC and a one-cycle `pc_from_rom_ready` strobe. Handles stalls from hazard logic and redirects from branch/jump resolution, discarding stale in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC of first fetch after reset; bits [1:0] must be 0.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pause` input 1: stall from hazard unit; while high no new instruction is presented.
- `jump_en` input 1: redirect request (taken branch/jump/flush).
- `jump_addr` input 32: redirect target; bits [1:0] are ignored (forced 0).
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_addr` output 32: fetch address (current PC).
- `imem_req_ready` input 1: memory accepts request this cycle.
- `imem_resp_valid` input 1: instruction word returned this cycle.
- `imem_resp_data` input 32: returned instruction.
- `if_pc` output 32: PC of presented instruction.
- `if_instr` output 32: presented instruction.
- `pc_from_rom_ready` output 1: `if_pc`/`if_instr` valid this cycle (1-cycle strobe per instruction).

## Operation
- At most one request outstanding; memory returns responses in order, one per accepted request.
- States: REQ, WAIT, HOLD, DROP.
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc. On `imem_req_ready` go WAIT.
- WAIT: on `imem_resp_valid` and !`pause`: register pc/data to outputs, strobe ready, pc<=pc+4, go REQ. On resp with `pause`: capture pc/data into hold buffer, go HOLD.
- HOLD: ready stays 0. When `pause` low: present buffer, strobe ready, pc<=pc+4, go REQ.
- DROP: waiting for a stale response; on `imem_resp_valid` discard it, go REQ. No output strobe.
- `jump_en` has highest priority in every state: pc<=jump_addr&~3, hold buffer invalidated, no strobe that cycle. Next state: REQ if no response is pending (REQ unaccepted, HOLD, WAIT/DROP with `imem_resp_valid` same cycle); DROP if a request is in flight (REQ accepted same cycle, WAIT/DROP without resp).
- In REQ with `jump_en` and no accept: request address changes to the new pc the next cycle; memory tolerates address change while unaccepted.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- `pause` does not block the request/response handshake, only presentation.

## Timing
- Reset (async assert): pc=RESET_PC, state REQ, `if_pc`=0, `if_instr`=32'h0000_0013, `pc_from_rom_ready`=0, hold buffer invalid. `imem_req_valid`=1 from first cycle after release.
- Outputs `if_pc`, `if_instr`, `pc_from_rom_ready` are registered; `imem_req_*` driven from state/pc registers only (no combinational path from inputs).
- Latency: request accepted cycle N, response cycle N+k, strobe in cycle N+k+1; next request asserted cycle N+k+1.
- Outside a strobe cycle, `if_pc`/`if_instr` retain last values; `pc_from_rom_ready`=0.
- Reset mid-operation abandons any in-flight request; the memory is reset by the same `rst_n`.

## Structure
- Shared pipeline package: state enum (REQ/WAIT/HOLD/DROP), `NOP_INSTR`=32'h0000_0013, `INSTR_BYTES`=4, reset-PC default.
- One natural sub-module: `pc_gen` (pc register, +4 increment, redirect mux with alignment mask). FSM and hold buffer stay in `if_fetch`.

## Test plan
- Reset release, `RESET_PC`=0, memory ready always, 1-cycle latency -> strobes with `if_pc`=0,4,8,… every 2 cycles, `if_instr` matching memory.
- `pause` high when response for pc 0x8 arrives, held 3 cycles -> no strobe while paused; strobe with pc 0x8 the cycle after `pause` falls; next request addr 0xC.
- `jump_en`, `jump_addr`=0x103 while in WAIT (no resp) -> stale response discarded, no strobe; next request addr 0x100; strobe `if_pc`=0x100.
- `jump_en` same cycle as `imem_resp_valid` -> response dropped, no DROP state, request to target next cycle.
- `jump_en` while HOLD -> buffered instruction never strobed; request to target after.
- PC 32'hFFFF_FFFC fetched -> next request addr 0; `rst_n` asserted mid-WAIT -> outputs immediately 0/NOP/0, fetch restarts at `RESET_PC`.
